// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 4-requester
// mux-select arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way rotate-priority picker: first set bit of (req & ~excl)
// scanning from ptr upward, modulo 4.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] excl,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [NUM_REQ-1:0] w_cand;

  assign w_cand = req & ~excl;

  // Scan farthest-first so the candidate closest to ptr is the last writer.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_cand[ptr + SEL_W'(k)]) begin
        idx   = ptr + SEL_W'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin scheduler for the shared 4:1 single-bit mux: drives the select,
// a one-hot grant and a registered data bit with valid. Define
// MUX_ARB_FIXED_PRI_EN for fixed priority req[0] > req[1] > req[2] > req[3].
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] d,
  output logic               s1,
  output logic               s0,
  output logic [NUM_REQ-1:0] gnt,
  output logic               o,
  output logic               vld
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  state_t             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [CNT_W-1:0]   r_hold, w_hold_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic               r_o, w_o_nxt;
  logic               r_vld, w_vld_nxt;

  logic [NUM_REQ-1:0] w_g_mask, w_excl;
  logic [SEL_W-1:0]   w_rel_ptr, w_pick_ptr, w_pick_idx;
  logic               w_pick_found, w_req_g, w_competitor, w_expire, w_release;

  // In GRANT the select always equals the granted index, so r_sel doubles as g.
  assign w_g_mask     = onehot(r_sel);
  assign w_req_g      = |(req & w_g_mask);
  assign w_competitor = |(req & ~w_g_mask);
  assign w_expire     = (r_state == GRANT) && (r_hold == HOLD_LIM) && w_competitor;
  assign w_release    = !w_req_g || w_expire;

`ifdef MUX_ARB_FIXED_PRI_EN
  assign w_rel_ptr = '0;
`else
  assign w_rel_ptr = r_sel + 1'b1;
`endif

  // One picker serves both the IDLE pick and the back-to-back re-pick.
  assign w_pick_ptr = (r_state == GRANT) ? w_rel_ptr : r_ptr;
  assign w_excl     = w_expire ? w_g_mask : '0;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (w_pick_ptr),
    .excl  (w_excl),
    .idx   (w_pick_idx),
    .found (w_pick_found)
  );

  always_comb begin
    // NOTE: every next-state value is defaulted first so no branch leaves one unassigned and infers a latch.
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_hold_nxt  = r_hold;
    w_gnt_nxt   = r_gnt;
    w_o_nxt     = r_o;
    w_vld_nxt   = r_vld;

    case (r_state)
      IDLE: begin
        w_vld_nxt = 1'b0;
        if (w_pick_found) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = onehot(w_pick_idx);
          w_sel_nxt   = w_pick_idx;
          w_hold_nxt  = CNT_W'(1);
        end
      end

      GRANT: begin
        w_o_nxt   = d[r_sel];
        w_vld_nxt = w_req_g;
        if (w_release) begin
          w_ptr_nxt = w_rel_ptr;
          if (w_pick_found) begin
            w_gnt_nxt  = onehot(w_pick_idx);
            w_sel_nxt  = w_pick_idx;
            w_hold_nxt = CNT_W'(1);
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
          end
        end else if (r_hold != HOLD_LIM) begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_hold  <= '0;
      r_gnt   <= '0;
      r_o     <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_hold  <= w_hold_nxt;
      r_gnt   <= w_gnt_nxt;
      r_o     <= w_o_nxt;
      r_vld   <= w_vld_nxt;
    end
  end

  assign s1  = r_sel[1];
  assign s0  = r_sel[0];
  assign gnt = r_gnt;
  assign o   = r_o;
  assign vld = r_vld;

endmodule
